bcd_xs3_serial_conv: RTL and testbench
======================================

BCD_XS3_SERIAL_CONV -- requirements
Module: bcd_xs3_serial_conv

Interface
REQ-001 Parameter DIGITS, default 4, number of 4-bit digits per word (range 1..16).
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset.
REQ-004 in_valid  input  1  source presents a word on in_data/dir.
REQ-005 in_ready  output  1  block accepts a word; transfer occurs when in_valid && in_ready.
REQ-006 dir  input  1  conversion direction: 0 = BCD->XS3, 1 = XS3->BCD; sampled at transfer.
REQ-007 in_data  input  4*DIGITS  packed digits; digit i is bits [4i+3:4i].
REQ-008 out_valid  output  1  converted word available.
REQ-009 out_ready  input  1  sink takes the word; transfer occurs when out_valid && out_ready.
REQ-010 out_data  output  4*DIGITS  converted digits, same packing as in_data.
REQ-011 digit_err  output  DIGITS  per-digit invalid-code flag, valid while out_valid.
REQ-012 err  output  1  OR of digit_err.

Function
REQ-013 FSM states SHALL be IDLE, CONV, DONE.
REQ-014 in_ready SHALL be 1 in IDLE only.
REQ-015 IDLE: on input transfer, latch in_data and dir, clear digit index to 0, clear digit_err, and go to CONV.
REQ-016 CONV: convert exactly one digit per cycle, digit 0 first. Write the result into the output register at the current index, then increment the index.
REQ-017 CONV: on the cycle that converts digit DIGITS-1, go to DONE and set out_valid.
REQ-018 Latency SHALL be exactly DIGITS cycles from the accepting edge to out_valid high.
REQ-019 DONE: out_valid, out_data, digit_err and err SHALL hold stable until an output transfer. On that transfer, clear out_valid and go to IDLE.
REQ-020 The block SHALL NOT accept a new word in the same cycle as an output transfer.
REQ-021 in_valid and in_data SHALL be ignored in CONV and DONE.
REQ-022 Valid digits: BCD->XS3 result = digit+3; XS3->BCD result = digit-3. Each is a 4-bit result.
REQ-023 Invalid input codes: BCD digit > 9; XS3 digit < 3 or > 12.
REQ-024 The digit index SHALL wrap to 0 after DIGITS-1.
REQ-025 With DIGITS=1, CONV lasts one cycle.

Reset
REQ-026 On rst_n low at a clock edge, the block SHALL enter IDLE with out_valid=0, out_data=0, digit_err=0, err=0 and index=0.
REQ-027 Reset in CONV or DONE SHALL discard the word in flight; no output transfer follows it.
REQ-028 in_ready SHALL be 1 in the first cycle after reset is released.

Configuration
REQ-029 Macro ERR_DETECT_EN defined: an invalid digit SHALL pass through unchanged and set its digit_err bit; err = |digit_err.
REQ-030 ERR_DETECT_EN undefined: digit_err and err SHALL be tied to 0. Every digit is converted modulo 16 (+3 or -3 wrap), with no check.

Structure
REQ-031 A shared package bcd_pkg SHALL hold XS3_OFFSET (4'd3), BCD_MAX (4'd9), XS3_MIN (4'd3), XS3_MAX (4'd12) and the FSM state enum.
REQ-032 A combinational sub-module xs3_digit_conv SHALL convert one digit. Ports: digit in, dir, result out, invalid flag out. It is instantiated once.

Verification (DIGITS=4)
REQ-033 dir=0, in_data=16'h1234 -> after 4 cycles out_valid=1, out_data=16'h4567, err=0.
REQ-034 dir=1, in_data=16'h4567 -> out_data=16'h1234, err=0.
REQ-035 dir=0, in_data=16'h9A05:
  - with ERR_DETECT_EN -> out_data=16'hCA38, digit_err=4'b0100, err=1.
  - without ERR_DETECT_EN -> out_data=16'hCD38, err=0.
REQ-036 dir=1, in_data=16'h0000 with ERR_DETECT_EN -> out_data=16'h0000, digit_err=4'hF, err=1.
REQ-037 out_ready held low 10 cycles in DONE -> out_valid, out_data and err stable; in_ready=0; in_valid pulses ignored. When out_ready rises -> IDLE next cycle.
REQ-038 rst_n low after 2 CONV cycles -> IDLE, out_valid=0, in_ready=1. Then dir=0, 16'h0000 -> out_data=16'h3333 after 4 cycles.

Source files
------------

// File: rtl/bcd_xs3_serial_conv_pkg.sv
// Shared constants and FSM state type for the serial BCD <-> excess-3 converter.
package bcd_pkg;

    localparam logic [3:0] XS3_OFFSET = 4'd3;
    localparam logic [3:0] BCD_MAX    = 4'd9;
    localparam logic [3:0] XS3_MIN    = 4'd3;
    localparam logic [3:0] XS3_MAX    = 4'd12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_xs3_serial_conv_if.sv
// Word-level handshake bundle: input word channel plus converted output channel.
interface bcd_xs3_serial_conv_if #(
    parameter int DIGITS = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic                  dir;
    logic [4*DIGITS-1:0]   in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   out_data;
    logic [DIGITS-1:0]     digit_err;
    logic                  err;

    // Converter side
    modport slave (
        input  in_valid, dir, in_data, out_ready,
        output in_ready, out_valid, out_data, digit_err, err
    );

    // Source/sink side
    modport master (
        output in_valid, dir, in_data, out_ready,
        input  in_ready, out_valid, out_data, digit_err, err
    );
endinterface

// File: rtl/bcd_xs3_serial_conv_xs3_digit_conv.sv
// Single-digit BCD <-> XS3 converter. With ERR_DETECT_EN, invalid codes pass
// through unchanged and are flagged; otherwise every code is converted mod 16.
module xs3_digit_conv
    import bcd_pkg::*;
(
    input  logic [3:0] digit_i,
    input  logic       dir_i,
    output logic [3:0] result_o,
    output logic       invalid_o
);

    logic [3:0] conv;

    always_comb begin
        conv = dir_i ? (digit_i - XS3_OFFSET) : (digit_i + XS3_OFFSET);
`ifdef ERR_DETECT_EN
        invalid_o = dir_i ? ((digit_i < XS3_MIN) || (digit_i > XS3_MAX))
                          : (digit_i > BCD_MAX);
        result_o  = invalid_o ? digit_i : conv;
`else
        invalid_o = 1'b0;
        result_o  = conv;
`endif
    end

endmodule

// File: rtl/bcd_xs3_serial_conv.sv
// Serial BCD <-> XS3 word converter: one digit per cycle, digit 0 first.
// Optional invalid-code detection is enabled by defining ERR_DETECT_EN.
module bcd_xs3_serial_conv
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    bcd_xs3_serial_conv_if.slave  bus
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [4*DIGITS-1:0]  data_in_q, data_in_d;
    logic                 dir_q, dir_d;
    logic [4*DIGITS-1:0]  out_data_q, out_data_d;
    logic [DIGITS-1:0]    digit_err_q, digit_err_d;
    logic                 out_valid_q, out_valid_d;

    logic [3:0]           conv_result;
    logic                 conv_invalid;

    xs3_digit_conv u_digit (
        .digit_i   (data_in_q[idx_q*4 +: 4]),
        .dir_i     (dir_q),
        .result_o  (conv_result),
        .invalid_o (conv_invalid)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            data_in_q   <= '0;
            dir_q       <= 1'b0;
            out_data_q  <= '0;
            digit_err_q <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            data_in_q   <= data_in_d;
            dir_q       <= dir_d;
            out_data_q  <= out_data_d;
            digit_err_q <= digit_err_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        data_in_d   = data_in_q;
        dir_d       = dir_q;
        out_data_d  = out_data_q;
        digit_err_d = digit_err_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    data_in_d   = bus.in_data;
                    dir_d       = bus.dir;
                    idx_d       = '0;
                    digit_err_d = '0;
                    state_d     = CONV;
                end
            end
            CONV: begin
                out_data_d[idx_q*4 +: 4] = conv_result;
                digit_err_d[idx_q]       = conv_invalid;
                if (idx_q == LAST_IDX) begin
                    idx_d       = '0;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                // Returning to IDLE first guarantees no accept on the output-transfer cycle.
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.digit_err = digit_err_q;
    assign bus.err       = |digit_err_q;

endmodule

// File: tb/tb_bcd_xs3_serial_conv.sv
// Directed bench for bcd_xs3_serial_conv (DIGITS=4); expectations follow ERR_DETECT_EN.
module tb_bcd_xs3_serial_conv;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fails  = 0;

    bcd_xs3_serial_conv_if #(.DIGITS(4)) bus ();

    bcd_xs3_serial_conv #(.DIGITS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one word, verify exact 4-cycle latency, then check the result in DONE.
    task automatic do_word(input string tag, input logic d, input logic [15:0] din,
                           input logic [15:0] exp_data, input logic [3:0] exp_derr);
        bus.in_valid = 1'b1;
        bus.dir      = d;
        bus.in_data  = din;
        tick();
        bus.in_valid = 1'b0;
        bus.in_data  = 16'hFFFF;
        check({tag, ".in_ready_conv"}, 32'(bus.in_ready), 32'd0);
        repeat (3) tick();
        check({tag, ".out_valid_early"}, 32'(bus.out_valid), 32'd0);
        tick();
        check({tag, ".out_valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, ".out_data"}, 32'(bus.out_data), 32'(exp_data));
        check({tag, ".digit_err"}, 32'(bus.digit_err), 32'(exp_derr));
        check({tag, ".err"}, 32'(bus.err), 32'(|exp_derr));
        $display("word %s dir=%0d in=%h out=%h derr=%b err=%0d", tag, d, din,
                 bus.out_data, bus.digit_err, bus.err);
    endtask

    task automatic drain(input string tag);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check({tag, ".out_valid_cleared"}, 32'(bus.out_valid), 32'd0);
        check({tag, ".in_ready_idle"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.dir       = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (2) tick();
        check("rst.out_valid", 32'(bus.out_valid), 32'd0);
        check("rst.out_data", 32'(bus.out_data), 32'd0);
        check("rst.digit_err", 32'(bus.digit_err), 32'd0);
        check("rst.err", 32'(bus.err), 32'd0);
        rst_n = 1'b1;
        tick();
        check("rst.in_ready_after_release", 32'(bus.in_ready), 32'd1);

        do_word("b2x_1234", 1'b0, 16'h1234, 16'h4567, 4'b0000);
        drain("b2x_1234");
        do_word("x2b_4567", 1'b1, 16'h4567, 16'h1234, 4'b0000);
        drain("x2b_4567");
        do_word("b2x_9999", 1'b0, 16'h9999, 16'hCCCC, 4'b0000);
        drain("b2x_9999");
        do_word("x2b_CCCC", 1'b1, 16'hCCCC, 16'h9999, 4'b0000);
        drain("x2b_CCCC");
        do_word("x2b_3333", 1'b1, 16'h3333, 16'h0000, 4'b0000);
        drain("x2b_3333");
`ifdef ERR_DETECT_EN
        do_word("b2x_9A05", 1'b0, 16'h9A05, 16'hCA38, 4'b0100);
        drain("b2x_9A05");
        do_word("x2b_0000", 1'b1, 16'h0000, 16'h0000, 4'b1111);
        drain("x2b_0000");
`else
        do_word("b2x_9A05", 1'b0, 16'h9A05, 16'hCD38, 4'b0000);
        drain("b2x_9A05");
        do_word("x2b_0000", 1'b1, 16'h0000, 16'hDDDD, 4'b0000);
        drain("x2b_0000");
`endif

        // Back-pressure in DONE with in_valid pulses that must be ignored.
        do_word("hold_0789", 1'b0, 16'h0789, 16'h3ABC, 4'b0000);
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = i[0];
            bus.dir      = 1'b1;
            bus.in_data  = 16'h5555 + 16'(i);
            tick();
            check("hold.out_valid", 32'(bus.out_valid), 32'd1);
            check("hold.out_data", 32'(bus.out_data), 32'h3ABC);
            check("hold.err", 32'(bus.err), 32'd0);
            check("hold.in_ready", 32'(bus.in_ready), 32'd0);
        end
        // in_valid stays high across the output transfer; it must not be taken then.
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check("hold.out_valid_cleared", 32'(bus.out_valid), 32'd0);
        check("hold.no_accept_on_out_xfer", 32'(bus.in_ready), 32'd1);
        $display("hold test done out_valid=%0d in_ready=%0d", bus.out_valid, bus.in_ready);

        // Reset in the middle of CONV drops the word.
        bus.in_valid = 1'b1;
        bus.dir      = 1'b0;
        bus.in_data  = 16'h1234;
        tick();
        bus.in_valid = 1'b0;
        repeat (2) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst.out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst.in_ready", 32'(bus.in_ready), 32'd1);
        repeat (6) tick();
        check("midrst.no_output", 32'(bus.out_valid), 32'd0);
        $display("mid-conv reset done out_valid=%0d", bus.out_valid);
        do_word("b2x_0000", 1'b0, 16'h0000, 16'h3333, 4'b0000);
        drain("b2x_0000");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
